// File: rtl/uart_pkg.sv
`default_nettype none
// uart_pkg: FSM state encoding and default bit timing shared by the UART RX and TX sides.
// Macro UART_RX_PARITY_EN adds the PARITY state. Rev 1.0
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// uart_rx_sync: two-flop synchronizer for the serial line, plus falling-edge detect. Rev 1.0
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_raw,
  output logic rx_sync,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // All three flops reset high so that an idle line never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= rx_raw;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rx_sync = sync;
  assign fall    = prev & ~sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// uart_rx: mid-bit sampling UART receiver with a valid/ready output holding register.
// Macro UART_RX_PARITY_EN adds an even-parity bit check. Rev 1.0
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic                  frame_err_o,
  output logic                  overrun_o,
  output logic                  parity_err_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_WIDTH - 1);

  logic                  rx_sync;
  logic                  rx_fall;
  uart_state_t           state;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] shift;
`ifdef UART_RX_PARITY_EN
  logic                  parity_bad;
`endif

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .rx_raw  (rx_i),
    .rx_sync (rx_sync),
    .fall    (rx_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      data_o      <= '0;
      valid_out   <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad   <= 1'b0;
      parity_err_o <= 1'b0;
`endif
    end else begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= 1'b0;
`endif
      // A completing byte later in this block overrides this clear.
      if (valid_out && ready_out) begin
        valid_out <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (rx_fall) begin
            state <= ST_START;
            cnt   <= HALF_LOAD;
          end
        end

        ST_START: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (rx_sync) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_DATA;
            cnt   <= FULL_LOAD;
            idx   <= '0;
          end
        end

        ST_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            shift <= {rx_sync, shift[DATA_WIDTH-1:1]};
            idx   <= idx + IDX_W'(1);
            cnt   <= FULL_LOAD;
            if (idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            parity_bad   <= (rx_sync != ^shift);
            parity_err_o <= (rx_sync != ^shift);
            cnt          <= FULL_LOAD;
            state        <= ST_STOP;
          end
        end
`endif

        ST_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= ST_IDLE;
            if (!rx_sync) begin
              frame_err_o <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (!parity_bad) begin
`else
            end else begin
`endif
              // The held byte wins if the consumer has not taken it yet.
              if (valid_out && !ready_out) begin
                overrun_o <= 1'b1;
              end else begin
                data_o    <= shift;
                valid_out <= 1'b1;
              end
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err_o = 1'b0;
`endif

endmodule
`default_nettype wire
